mlp_sequencer: RTL and testbench

MLP_SEQUENCER -- requirements
Module: mlp_sequencer

---
 rtl/mlp_sequencer_pkg.sv | 18 +
 rtl/mlp_sequencer.sv | 173 +++++++++++++++++
 tb/tb_mlp_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_sequencer_pkg.sv
// Shared definitions for the MLP layer sequencer.
// Holds the 4-bit sequencer state encoding used by the RTL and by benches
// that observe or drive the sequencer.
package mlp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_LOAD_WEIGHT  = 4'd1,
        ST_LOAD_ACT     = 4'd2,
        ST_COMPUTE      = 4'd3,
        ST_DRAIN        = 4'd4,
        ST_TRANSFER     = 4'd5,
        ST_NEXT_LAYER   = 4'd6,
        ST_WAIT_WEIGHTS = 4'd7,
        ST_DONE         = 4'd8
    } state_t;

endpackage

// File: rtl/mlp_sequencer.sv
// MLP layer sequencer for an N x N systolic array.
// Steps a multi-layer run through weight load, activation load (first layer
// only), compute, drain, activation transfer and weight wait, ping-ponging
// the activation buffers between layers.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   start               run request (IDLE only)
//   cfg_num_layers      layer count, latched on an accepted start
//   abort               synchronous abort back to IDLE
//   act_ready           initial activations present in buffer A
//   weights_ready       next layer's weights present in the FIFO
//   state, cycle_cnt    current state and per-state cycle count
//   layer, buf_sel      current layer index and read buffer
//   wf_pop, capture     weight FIFO pop and one-hot column capture
//   ub_rd_en            activation buffer read enable
//   mmu_valid, acc_en   accumulator valid and accumulate/overwrite select
//   refill_en           refill write window for the other buffer
//   busy, done, err_cfg run status, completion pulse, rejected-start pulse
module mlp_sequencer
    import mlp_pkg::*;
#(
    parameter  int N          = 2,
    parameter  int MAX_LAYERS = 8,
    parameter  int XFER_CYC   = 4,
    localparam int CW         = $clog2(2*N+3),
    localparam int LW         = $clog2(MAX_LAYERS+1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [LW-1:0] cfg_num_layers,
    input  logic          abort,
    input  logic          act_ready,
    input  logic          weights_ready,
    output state_t        state,
    output logic [CW-1:0] cycle_cnt,
    output logic [LW-1:0] layer,
    output logic          buf_sel,
    output logic          wf_pop,
    output logic [N-1:0]  capture,
    output logic          ub_rd_en,
    output logic          mmu_valid,
    output logic          acc_en,
    output logic          refill_en,
    output logic          busy,
    output logic          done,
    output logic          err_cfg
);

    // The internal counter must also reach XFER_CYC-1, which can exceed the
    // CW-bit visible counter for small N; the visible value saturates.
    localparam int XW = $clog2(XFER_CYC+1);
    localparam int IW = (XW > CW) ? XW : CW;

    localparam logic [IW-1:0] CNT_SAT    = IW'((1 << CW) - 1);
    localparam logic [IW-1:0] LDW_LAST   = IW'(N);
    localparam logic [IW-1:0] COMP_LAST  = IW'(N);
    localparam logic [IW-1:0] DRAIN_LAST = IW'(2*N+2);
    localparam logic [IW-1:0] XFER_LAST  = IW'(XFER_CYC-1);

    state_t          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   layer_q, layer_d;
    logic [LW-1:0]   nl_q, nl_d;
    logic            buf_q, buf_d;
    logic            err_q, err_d;

    logic            cfg_ok;
    logic            more_layers;

    assign cfg_ok      = (cfg_num_layers != '0) && (cfg_num_layers <= LW'(MAX_LAYERS));
    assign more_layers = ((LW+1)'(layer_q) + (LW+1)'(1)) < (LW+1)'(nl_q);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:         if (start && cfg_ok) state_d = ST_LOAD_WEIGHT;
            ST_LOAD_WEIGHT:  if (cnt_q == LDW_LAST)
                                 state_d = (layer_q == '0) ? ST_LOAD_ACT : ST_COMPUTE;
            ST_LOAD_ACT:     if (act_ready) state_d = ST_COMPUTE;
            ST_COMPUTE:      if (cnt_q == COMP_LAST) state_d = ST_DRAIN;
            ST_DRAIN:        if (cnt_q == DRAIN_LAST)
                                 state_d = more_layers ? ST_TRANSFER : ST_DONE;
            ST_TRANSFER:     if (cnt_q == XFER_LAST) state_d = ST_NEXT_LAYER;
            ST_NEXT_LAYER:   state_d = ST_WAIT_WEIGHTS;
            ST_WAIT_WEIGHTS: if (weights_ready) state_d = ST_LOAD_WEIGHT;
            ST_DONE:         state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
        if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
    end

    // Counter, layer bookkeeping and config-error next state
    always_comb begin
        cnt_d   = cnt_q;
        layer_d = layer_q;
        nl_d    = nl_q;
        buf_d   = buf_q;
        err_d   = 1'b0;

        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            cnt_d = '0;
        end else if (!(((state_q == ST_LOAD_ACT) || (state_q == ST_WAIT_WEIGHTS))
                       && (cnt_q == CNT_SAT))) begin
            cnt_d = cnt_q + IW'(1);
        end

        if ((state_q == ST_IDLE) && start) begin
            if (cfg_ok) begin
                layer_d = '0;
                buf_d   = 1'b0;
                nl_d    = cfg_num_layers;
            end else begin
                err_d   = 1'b1;
            end
        end

        // The filled buffer becomes the read buffer for the next layer
        if ((state_q == ST_NEXT_LAYER) && !abort) begin
            layer_d = layer_q + LW'(1);
            buf_d   = ~buf_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            layer_q <= '0;
            nl_q    <= '0;
            buf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            layer_q <= layer_d;
            nl_q    <= nl_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    // Output decode from registered state and counter only
    always_comb begin
        state     = state_q;
        layer     = layer_q;
        buf_sel   = buf_q;
        err_cfg   = err_q;
        cycle_cnt = (cnt_q > CNT_SAT) ? {CW{1'b1}} : cnt_q[CW-1:0];
        wf_pop    = (state_q == ST_LOAD_WEIGHT);
        ub_rd_en  = (state_q == ST_COMPUTE);
        mmu_valid = ((state_q == ST_COMPUTE) && (cnt_q >= COMP_LAST)) || (state_q == ST_DRAIN);
        acc_en    = (state_q == ST_DRAIN);
        refill_en = (state_q == ST_DRAIN) || (state_q == ST_TRANSFER);
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        capture   = '0;
        // Column k latches its weights one cycle after its row reaches it
        for (int k = 0; k < N; k++) begin
            capture[k] = (state_q == ST_LOAD_WEIGHT) && (cnt_q == IW'(k+1));
        end
    end

endmodule

// File: tb/tb_mlp_sequencer.sv
// Directed bench for mlp_sequencer: an N=2 instance for the main sequencing
// cases and an N=4, XFER_CYC=2 instance for the parameterised timing case.
module tb_mlp_sequencer;
    import mlp_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // N=2 instance
    logic       start, abort, act_ready, weights_ready;
    logic [3:0] cfg;
    state_t     st;
    logic [2:0] cc;
    logic [3:0] layer;
    logic       buf_sel, wf_pop, ub_rd_en, mmu_valid, acc_en, refill_en, busy, done, err_cfg;
    logic [1:0] capture;

    // N=4 instance
    logic       start4, abort4, act4, wr4;
    logic [3:0] cfg4;
    state_t     st4;
    logic [3:0] cc4;
    logic [3:0] layer4;
    logic       buf4, wf4, ub4, mv4, acc4, rf4, busy4, done4, err4;
    logic [3:0] cap4;

    mlp_sequencer #(.N(2), .MAX_LAYERS(8), .XFER_CYC(4)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_num_layers(cfg), .abort(abort),
        .act_ready(act_ready), .weights_ready(weights_ready), .state(st), .cycle_cnt(cc),
        .layer(layer), .buf_sel(buf_sel), .wf_pop(wf_pop), .capture(capture),
        .ub_rd_en(ub_rd_en), .mmu_valid(mmu_valid), .acc_en(acc_en), .refill_en(refill_en),
        .busy(busy), .done(done), .err_cfg(err_cfg)
    );

    mlp_sequencer #(.N(4), .MAX_LAYERS(8), .XFER_CYC(2)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .cfg_num_layers(cfg4), .abort(abort4),
        .act_ready(act4), .weights_ready(wr4), .state(st4), .cycle_cnt(cc4),
        .layer(layer4), .buf_sel(buf4), .wf_pop(wf4), .capture(cap4),
        .ub_rd_en(ub4), .mmu_valid(mv4), .acc_en(acc4), .refill_en(rf4),
        .busy(busy4), .done(done4), .err_cfg(err4)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int sq[$];
    int cq[$];
    int lq[$];
    int bq[$];
    int exp_sq[6] = '{1, 2, 3, 4, 8, 0};
    int busy_n, done_n, acc_n, mv_n, rf_n, tx_n, ww_n, acc_bad, comp_n, drain_n, mv_first;
    bit found, first_set;
    state_t prev;

    initial begin
        reset = 1'b0;
        start = 0; abort = 0; act_ready = 0; weights_ready = 0; cfg = 0;
        start4 = 0; abort4 = 0; act4 = 0; wr4 = 0; cfg4 = 0;
        #1 reset = 1'b1;
        #1;
        // ---------- reset values ----------
        chk("rst_state", 32'(st), 0);
        chk("rst_cnt", 32'(cc), 0);
        chk("rst_layer", 32'(layer), 0);
        chk("rst_buf", 32'(buf_sel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err_cfg), 0);
        chk("rst_strobes", 32'({wf_pop, capture, ub_rd_en, mmu_valid, acc_en, refill_en}), 0);
        tick();
        tick();
        reset = 1'b0;

        // ---------- single-layer run ----------
        cfg = 1; start = 1; act_ready = 0;
        prev = ST_IDLE; busy_n = 0; done_n = 0; acc_n = 0; mv_n = 0; rf_n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            start = 0;
            if (st != prev) begin sq.push_back(int'(st)); prev = st; end
            if (st == ST_LOAD_WEIGHT && capture != 0) cq.push_back(int'(capture));
            busy_n += int'(busy); done_n += int'(done); acc_n += int'(acc_en);
            mv_n += int'(mv_n >= 0 && mmu_valid); rf_n += int'(refill_en);
            act_ready = (st == ST_LOAD_ACT && cc == 3'd1);
        end
        chk("t1_seq_len", 32'(sq.size()), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t1_seq%0d", i), 32'(sq[i]), 32'(exp_sq[i]));
        chk("t1_cap_len", 32'(cq.size()), 2);
        chk("t1_cap0", 32'(cq[0]), 1);
        chk("t1_cap1", 32'(cq[1]), 2);
        chk("t1_busy_cycles", 32'(busy_n), 16);
        chk("t1_done_pulses", 32'(done_n), 1);
        chk("t1_acc_cycles", 32'(acc_n), 7);
        chk("t1_mmu_cycles", 32'(mv_n), 8);
        chk("t1_refill_cycles", 32'(rf_n), 7);

        // ---------- rejected configurations ----------
        cfg = 0; start = 1;
        tick(); start = 0;
        chk("t2_err_cfg0", 32'(err_cfg), 1);
        chk("t2_state_cfg0", 32'(st), 0);
        chk("t2_busy_cfg0", 32'(busy), 0);
        tick();
        chk("t2_err_clear0", 32'(err_cfg), 0);
        cfg = 9; start = 1;
        tick(); start = 0;
        chk("t2_err_cfg9", 32'(err_cfg), 1);
        chk("t2_state_cfg9", 32'(st), 0);
        tick();
        chk("t2_err_clear9", 32'(err_cfg), 0);
        cfg = 8; start = 1;
        tick(); start = 0;
        chk("t2_accept_max", 32'(st), 1);
        chk("t2_no_err_max", 32'(err_cfg), 0);
        abort = 1; tick(); abort = 0;
        chk("t2_abort_lw", 32'(st), 0);

        // ---------- three layers, ping-pong buffers ----------
        cfg = 3; start = 1; act_ready = 1; weights_ready = 1;
        tx_n = 0; ww_n = 0; acc_n = 0; acc_bad = 0; done_n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            start = 0;
            if (st == ST_COMPUTE && cc == 0) begin lq.push_back(int'(layer)); bq.push_back(int'(buf_sel)); end
            if (st == ST_TRANSFER && cc == 0) tx_n++;
            if (st == ST_WAIT_WEIGHTS) ww_n++;
            if (acc_en) acc_n++;
            if (acc_en && st != ST_DRAIN) acc_bad++;
            done_n += int'(done);
            // a start during a run must be ignored
            if (st == ST_COMPUTE && layer == 1 && cc == 0) begin start = 1; cfg = 1; end
            if (done_n > 0 && st == ST_IDLE) break;
        end
        chk("t3_layers_len", 32'(lq.size()), 3);
        for (int i = 0; i < 3; i++) chk($sformatf("t3_layer%0d", i), 32'(lq[i]), 32'(i));
        chk("t3_buf0", 32'(bq[0]), 0);
        chk("t3_buf1", 32'(bq[1]), 1);
        chk("t3_buf2", 32'(bq[2]), 0);
        chk("t3_transfers", 32'(tx_n), 2);
        chk("t3_ww_cycles", 32'(ww_n), 2);
        chk("t3_acc_cycles", 32'(acc_n), 21);
        chk("t3_acc_outside_drain", 32'(acc_bad), 0);
        chk("t3_done_pulses", 32'(done_n), 1);
        chk("t3_end_idle", 32'(st), 0);

        // ---------- LOAD_ACT saturation, abort in DRAIN ----------
        act_ready = 0; cfg = 1; start = 1;
        tick(); start = 0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (st == ST_LOAD_ACT) begin found = 1; break; end
            tick();
        end
        chk("t4_reach_load_act", 32'(found), 1);
        for (int i = 0; i < 12; i++) tick();
        chk("t4_la_state", 32'(st), 2);
        chk("t4_la_saturate", 32'(cc), 7);
        abort = 1; tick(); abort = 0;
        chk("t4_abort_la", 32'(st), 0);
        act_ready = 1; cfg = 1; start = 1;
        tick(); start = 0;
        found = 0;
        for (int i = 0; i < 50; i++) begin
            if (st == ST_DRAIN && cc == 3) begin found = 1; break; end
            tick();
        end
        chk("t4_reach_drain3", 32'(found), 1);
        chk("t4_acc_in_drain", 32'(acc_en), 1);
        abort = 1; tick(); abort = 0;
        chk("t4_abort_state", 32'(st), 0);
        chk("t4_abort_done", 32'(done), 0);
        chk("t4_abort_busy", 32'(busy), 0);
        chk("t4_abort_strobes", 32'({wf_pop, capture, ub_rd_en, mmu_valid, acc_en, refill_en}), 0);
        tick();
        chk("t4_abort_done_late", 32'(done), 0);
        cfg = 1; start = 1; done_n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            start = 0;
            done_n += int'(done);
        end
        chk("t4_rerun_done", 32'(done_n), 1);
        chk("t4_rerun_idle", 32'(st), 0);

        // ---------- asynchronous reset in COMPUTE ----------
        cfg = 2; start = 1; act_ready = 1; weights_ready = 1;
        tick(); start = 0;
        found = 0;
        for (int i = 0; i < 60; i++) begin
            if (st == ST_COMPUTE && layer == 1) begin found = 1; break; end
            tick();
        end
        chk("t5_reach_compute_l1", 32'(found), 1);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_state", 32'(st), 0);
        chk("t5_rst_cnt", 32'(cc), 0);
        chk("t5_rst_layer", 32'(layer), 0);
        chk("t5_rst_buf", 32'(buf_sel), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_strobes", 32'({wf_pop, capture, ub_rd_en, mmu_valid, acc_en, refill_en, done}), 0);
        tick();
        reset = 1'b0;
        cfg = 1; start = 1;
        tick(); start = 0;
        chk("t5_start_after_rst", 32'(st), 1);
        abort = 1; tick(); abort = 0;
        chk("t5_cleanup_idle", 32'(st), 0);

        // ---------- N=4, XFER_CYC=2, late weights ----------
        cfg4 = 2; start4 = 1; act4 = 1; wr4 = 0;
        comp_n = 0; drain_n = 0; ww_n = 0; tx_n = 0; done_n = 0; mv_first = -1; first_set = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            start4 = 0;
            if (st4 == ST_COMPUTE && layer4 == 0) comp_n++;
            if (st4 == ST_DRAIN && layer4 == 0) drain_n++;
            if (st4 == ST_COMPUTE && mv4 && !first_set) begin mv_first = int'(cc4); first_set = 1; end
            if (st4 == ST_WAIT_WEIGHTS) ww_n++;
            if (st4 == ST_TRANSFER) tx_n++;
            done_n += int'(done4);
            wr4 = (st4 == ST_WAIT_WEIGHTS && cc4 >= 4'd5);
            if (done_n > 0 && st4 == ST_IDLE) break;
        end
        chk("t6_compute_cycles", 32'(comp_n), 5);
        chk("t6_drain_cycles", 32'(drain_n), 11);
        chk("t6_mmu_first_cnt", 32'(mv_first), 4);
        chk("t6_ww_cycles", 32'(ww_n), 6);
        chk("t6_xfer_cycles", 32'(tx_n), 2);
        chk("t6_done_pulses", 32'(done_n), 1);
        chk("t6_end_idle", 32'(st4), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
